// File: rtl/proc_pkg.sv
// Shared types and instruction-field helpers for the parametrised processor core.
package proc_pkg;

   typedef enum logic [3:0] {
      OP_NOP   = 4'd0,
      OP_ADD   = 4'd1,
      OP_SUB   = 4'd2,
      OP_AND   = 4'd3,
      OP_OR    = 4'd4,
      OP_LOAD  = 4'd5,
      OP_STORE = 4'd6,
      OP_MOV   = 4'd7,
      OP_LDI   = 4'd8
   } opcode_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_WB   = 2'd2
   } state_e;

   // Highest defined opcode; anything above retires as an illegal NOP.
   localparam logic [3:0] OP_LAST = 4'd8;

   // Extract a w-bit field starting at lsb from an instruction word.
   function automatic logic [31:0] field(input logic [31:0] word, input int unsigned lsb,
                                         input int unsigned w);
      return (word >> lsb) & ((32'd1 << w) - 32'd1);
   endfunction

   // Word layout is {opcode, rd, rs, addr}.
   function automatic logic [31:0] instr_op(input logic [31:0] word, input int unsigned ra_w,
                                            input int unsigned ma_w);
      return field(word, 2 * ra_w + ma_w, 4);
   endfunction

   function automatic logic [31:0] instr_rd(input logic [31:0] word, input int unsigned ra_w,
                                            input int unsigned ma_w);
      return field(word, ra_w + ma_w, ra_w);
   endfunction

   function automatic logic [31:0] instr_rs(input logic [31:0] word, input int unsigned ra_w,
                                            input int unsigned ma_w);
      return field(word, ma_w, ra_w);
   endfunction

   function automatic logic [31:0] instr_addr(input logic [31:0] word, input int unsigned ma_w);
      return field(word, 0, ma_w);
   endfunction

endpackage

// File: rtl/proc_core_param_alu.sv
// Combinational ALU: two-operand arithmetic/logic plus the flag results.
module proc_alu
   import proc_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  opcode_e           op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result,
   output logic              carry,
   output logic              zero,
   output logic              updates_flags
);

   logic [DATA_W:0] ext;

   // One extra bit on ADD/SUB gives carry-out and borrow directly.
   always_comb begin
      ext           = '0;
      result        = '0;
      carry         = 1'b0;
      updates_flags = 1'b0;
      case (op)
         OP_ADD: begin
            ext           = {1'b0, a} + {1'b0, b};
            result        = ext[DATA_W-1:0];
            carry         = ext[DATA_W];
            updates_flags = 1'b1;
         end
         OP_SUB: begin
            ext           = {1'b0, a} - {1'b0, b};
            result        = ext[DATA_W-1:0];
            carry         = ext[DATA_W];
            updates_flags = 1'b1;
         end
         OP_AND: begin
            result        = a & b;
            updates_flags = 1'b1;
         end
         OP_OR: begin
            result        = a | b;
            updates_flags = 1'b1;
         end
         OP_MOV:  result = b;
         default: result = '0;
      endcase
      zero = (result == '0);
   end

endmodule

// File: rtl/proc_core_param.sv
// Multi-cycle processor core: IDLE -> EXEC -> WB, register file and data memory in flops.
module proc_core_param
   import proc_pkg::*;
#(
   parameter  int DATA_W    = 8,
   parameter  int NREG      = 4,
   parameter  int MEM_DEPTH = 16,
   localparam int RA_W      = $clog2(NREG),
   localparam int MA_W      = $clog2(MEM_DEPTH),
   localparam int INSTR_W   = 4 + 2 * RA_W + MA_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic [INSTR_W-1:0] instr,
   output logic               done,
   output logic               illegal,
   output logic [DATA_W-1:0]  alu_result_debug,
   output logic               flag_zero,
   output logic               flag_carry,
   input  logic [RA_W-1:0]    dbg_sel,
   output logic [DATA_W-1:0]  dbg_data
);

   state_e              state_q, state_d;
   logic [INSTR_W-1:0]  instr_q, instr_d;
   logic [DATA_W-1:0]   regs_q [NREG];
   logic [DATA_W-1:0]   regs_d [NREG];
   logic [DATA_W-1:0]   mem_q  [MEM_DEPTH];
   logic [DATA_W-1:0]   mem_d  [MEM_DEPTH];
   logic [DATA_W-1:0]   res_q, res_d;
   logic                alu_c_q, alu_c_d, alu_z_q, alu_z_d, alu_u_q, alu_u_d;
   logic                fz_q, fz_d, fc_q, fc_d;
   logic                done_q, done_d, ill_q, ill_d;

   logic [31:0]         iw;
   logic [3:0]          op_raw;
   opcode_e             op;
   logic [RA_W-1:0]     rd, rs;
   logic [MA_W-1:0]     addr;
   logic [DATA_W-1:0]   alu_res;
   logic                alu_c, alu_z, alu_u;
   logic                writes_rd;

   // Decode the latched instruction word.
   always_comb begin
      iw     = 32'(instr_q);
      op_raw = 4'(instr_op(iw, RA_W, MA_W));
      op     = opcode_e'(op_raw);
      rd     = RA_W'(instr_rd(iw, RA_W, MA_W));
      rs     = RA_W'(instr_rs(iw, RA_W, MA_W));
      addr   = MA_W'(instr_addr(iw, MA_W));
   end

   proc_alu #(.DATA_W(DATA_W)) u_alu (
      .op            (op),
      .a             (regs_q[rd]),
      .b             (regs_q[rs]),
      .result        (alu_res),
      .carry         (alu_c),
      .zero          (alu_z),
      .updates_flags (alu_u)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state: accept only in IDLE, then a fixed EXEC/WB sequence.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (instr_valid) state_d = S_EXEC;
         S_EXEC:  state_d = S_WB;
         S_WB:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      instr_ready = (state_q == S_IDLE);
   end

   // Opcodes that write rd at WB.
   always_comb begin
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LOAD, OP_MOV, OP_LDI: writes_rd = 1'b1;
         default:                                                writes_rd = 1'b0;
      endcase
   end

   // Datapath: latch at accept, compute in EXEC, commit architectural state in WB.
   always_comb begin
      instr_d = instr_q;
      regs_d  = regs_q;
      mem_d   = mem_q;
      res_d   = res_q;
      alu_c_d = alu_c_q;
      alu_z_d = alu_z_q;
      alu_u_d = alu_u_q;
      fz_d    = fz_q;
      fc_d    = fc_q;
      done_d  = 1'b0;
      ill_d   = 1'b0;
      case (state_q)
         S_IDLE: if (instr_valid) instr_d = instr;
         S_EXEC: begin
            if (op == OP_LOAD)     res_d = mem_q[addr];
            else if (op == OP_LDI) res_d = DATA_W'(addr);
            else                   res_d = alu_res;
            alu_c_d = alu_c;
            alu_z_d = alu_z;
            alu_u_d = alu_u;
         end
         S_WB: begin
            done_d = 1'b1;
            ill_d  = (op_raw > OP_LAST);
            if (writes_rd)       regs_d[rd] = res_q;
            if (op == OP_STORE)  mem_d[addr] = regs_q[rs];
            if (alu_u_q) begin
               fz_d = alu_z_q;
               fc_d = alu_c_q;
            end
         end
         default: ;
      endcase
   end

   // Datapath registers; reset aborts any in-flight instruction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_q <= '0;
         regs_q  <= '{default: '0};
         mem_q   <= '{default: '0};
         res_q   <= '0;
         alu_c_q <= 1'b0;
         alu_z_q <= 1'b0;
         alu_u_q <= 1'b0;
         fz_q    <= 1'b0;
         fc_q    <= 1'b0;
         done_q  <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         instr_q <= instr_d;
         regs_q  <= regs_d;
         mem_q   <= mem_d;
         res_q   <= res_d;
         alu_c_q <= alu_c_d;
         alu_z_q <= alu_z_d;
         alu_u_q <= alu_u_d;
         fz_q    <= fz_d;
         fc_q    <= fc_d;
         done_q  <= done_d;
         ill_q   <= ill_d;
      end
   end

   assign done             = done_q;
   assign illegal          = ill_q;
   assign alu_result_debug = res_q;
   assign flag_zero        = fz_q;
   assign flag_carry       = fc_q;
   assign dbg_data         = regs_q[dbg_sel];

endmodule

// File: tb/tb_proc_core_param.sv
// Randomised + directed bench for proc_core_param against an instruction-level model.
module tb_proc_core_param;

   localparam int DATA_W = 8;
   localparam int NREG = 4;
   localparam int MEM_DEPTH = 16;
   localparam int INSTR_W = 12;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               instr_valid = 1'b0;
   logic               instr_ready;
   logic [INSTR_W-1:0] instr = '0;
   logic               done, illegal;
   logic [DATA_W-1:0]  alu_result_debug;
   logic               flag_zero, flag_carry;
   logic [1:0]         dbg_sel = '0;
   logic [DATA_W-1:0]  dbg_data;

   int n_chk = 0;
   int n_fail = 0;

   // Instruction-level model state.
   int m_reg [NREG];
   int m_mem [MEM_DEPTH];
   int m_z, m_c, m_res, m_ill;

   proc_core_param #(.DATA_W(DATA_W), .NREG(NREG), .MEM_DEPTH(MEM_DEPTH)) dut (
      .clk              (clk),
      .rst              (rst),
      .instr_valid      (instr_valid),
      .instr_ready      (instr_ready),
      .instr            (instr),
      .done             (done),
      .illegal          (illegal),
      .alu_result_debug (alu_result_debug),
      .flag_zero        (flag_zero),
      .flag_carry       (flag_carry),
      .dbg_sel          (dbg_sel),
      .dbg_data         (dbg_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [INSTR_W-1:0] enc(input int op, input int rd, input int rs, input int ad);
      return {4'(op), 2'(rd), 2'(rs), 4'(ad)};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NREG; i++) m_reg[i] = 0;
      for (int i = 0; i < MEM_DEPTH; i++) m_mem[i] = 0;
      m_z = 0; m_c = 0; m_res = 0; m_ill = 0;
   endtask

   // Architectural effect of one instruction, straight from the opcode table.
   task automatic model(input logic [INSTR_W-1:0] w);
      int op, rd, rs, ad, a, b;
      op = int'(w[11:8]); rd = int'(w[7:6]); rs = int'(w[5:4]); ad = int'(w[3:0]);
      a = m_reg[rd]; b = m_reg[rs];
      m_ill = (op > 8) ? 1 : 0;
      m_res = 0;
      case (op)
         1: begin m_res = (a + b) % 256; m_c = (a + b > 255); m_z = (m_res == 0); m_reg[rd] = m_res; end
         2: begin m_res = (a - b + 256) % 256; m_c = (a < b); m_z = (m_res == 0); m_reg[rd] = m_res; end
         3: begin m_res = a & b; m_c = 0; m_z = (m_res == 0); m_reg[rd] = m_res; end
         4: begin m_res = a | b; m_c = 0; m_z = (m_res == 0); m_reg[rd] = m_res; end
         5: begin m_res = m_mem[ad]; m_reg[rd] = m_res; end
         6: m_mem[ad] = b;
         7: begin m_res = b; m_reg[rd] = m_res; end
         8: begin m_res = ad; m_reg[rd] = m_res; end
         default: ;
      endcase
   endtask

   task automatic cmp_state(input string t);
      chk({t, "_alu"}, int'(alu_result_debug), m_res);
      chk({t, "_z"}, int'(flag_zero), m_z);
      chk({t, "_c"}, int'(flag_carry), m_c);
      for (int i = 0; i < NREG; i++) begin
         dbg_sel = 2'(i);
         #1;
         chk($sformatf("%s_r%0d", t, i), int'(dbg_data), m_reg[i]);
      end
   endtask

   // Issue one instruction from an idle core; entered and left at posedge+1.
   task automatic run_one(input logic [INSTR_W-1:0] w);
      int n;
      instr_valid = 1'b1;
      instr = w;
      @(negedge clk);
      chk("idle_ready", int'(instr_ready), 1);
      @(posedge clk); #1;
      instr_valid = 1'b0;
      instr = ~w;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (!done && n < 3) chk("busy_ready", int'(instr_ready), 0);
      end while (!done && n < 10);
      chk("done_lat", n, 3);
      model(w);
      chk("illegal", int'(illegal), m_ill);
      cmp_state("st");
      @(negedge clk);
      chk("done_pulse", int'(done), 0);
      chk("ill_pulse", int'(illegal), 0);
      @(posedge clk); #1;
   endtask

   task automatic chk_reg(input string t, input int idx, input int exp);
      dbg_sel = 2'(idx);
      #1;
      chk(t, int'(dbg_data), exp);
   endtask

   initial begin
      logic [INSTR_W-1:0] seq [3];
      int k, cyc, ndone, hs, op;
      int acc [3];

      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", int'(instr_ready), 1);
      chk("rst_done", int'(done), 0);
      chk("rst_ill", int'(illegal), 0);
      cmp_state("rst");
      @(posedge clk); #1;

      // ADD without carry
      run_one(enc(8, 0, 0, 9));
      run_one(enc(8, 1, 0, 5));
      run_one(enc(1, 0, 1, 0));
      chk_reg("add_r0", 0, 8'h0E);
      chk("add_z", int'(flag_zero), 0);
      chk("add_c", int'(flag_carry), 0);

      // SUB with borrow, then rd == rs
      run_one(enc(8, 0, 0, 5));
      run_one(enc(8, 1, 0, 9));
      run_one(enc(2, 0, 1, 0));
      chk_reg("sub_r0", 0, 8'hFC);
      chk("sub_c", int'(flag_carry), 1);
      run_one(enc(2, 1, 1, 0));
      chk_reg("subrr_r1", 1, 0);
      chk("subrr_z", int'(flag_zero), 1);
      chk("subrr_c", int'(flag_carry), 0);

      // STORE then LOAD back-to-back from the same address
      run_one(enc(8, 0, 0, 14));
      run_one(enc(6, 0, 0, 3));
      run_one(enc(8, 0, 0, 0));
      run_one(enc(5, 0, 0, 3));
      chk_reg("load_r0", 0, 8'h0E);

      // valid held high: accepts exactly 3 cycles apart, busy-time instr changes ignored
      seq[0] = enc(7, 2, 1, 0);
      seq[1] = enc(3, 2, 0, 0);
      seq[2] = enc(4, 3, 2, 0);
      k = 0; cyc = 0; ndone = 0;
      instr_valid = 1'b1;
      instr = seq[0];
      while (k < 3 && cyc < 30) begin
         @(negedge clk);
         cyc++;
         if (done) ndone++;
         hs = (instr_valid && instr_ready) ? 1 : 0;
         if (hs != 0) begin acc[k] = cyc; k++; end
         @(posedge clk); #1;
         if (hs != 0) begin
            if (k < 3) instr = ~seq[k];
            else instr_valid = 1'b0;
         end else if (k < 3) instr = seq[k];
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done) ndone++;
         @(posedge clk); #1;
      end
      chk("b2b_accepts", k, 3);
      if (k == 3) begin
         chk("b2b_gap1", acc[1] - acc[0], 3);
         chk("b2b_gap2", acc[2] - acc[1], 3);
      end
      chk("b2b_dones", ndone, 3);
      for (int i = 0; i < 3; i++) model(seq[i]);
      @(negedge clk);
      cmp_state("b2b");
      @(posedge clk); #1;

      // illegal opcode
      run_one(enc(15, 1, 2, 7));
      run_one(enc(5, 1, 0, 3));

      // random program
      for (int i = 0; i < 60; i++) begin
         op = int'($urandom_range(0, 10));
         if (op == 10) op = int'($urandom_range(9, 15));
         run_one(enc(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 15))));
      end

      // reset during WB of ADD r0,r1
      run_one(enc(8, 0, 0, 9));
      run_one(enc(8, 1, 0, 5));
      run_one(enc(1, 0, 1, 0));
      instr_valid = 1'b1;
      instr = enc(1, 0, 1, 0);
      @(posedge clk); #1;
      instr_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("wbrst_done", int'(done), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      model_reset();
      chk("wbrst_ready", int'(instr_ready), 1);
      chk("wbrst_done2", int'(done), 0);
      cmp_state("wbrst");
      @(posedge clk); #1;
      run_one(enc(5, 2, 0, 3));

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
